// File: rtl/sbc16_bus_pkg.sv
// sbc16_bus_pkg
// Shared definitions for the sbc16 RAM arbiter: arbiter FSM state encoding,
// master index constants and default bus widths.
package sbc16_bus_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 16;

    // Master indices; also the bit positions in the request vector.
    localparam logic M_CPU = 1'b0;
    localparam logic M_LDR = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_e;

endpackage

// File: rtl/sbc16_rr_pick2.sv
// sbc16_rr_pick2
// Combinational two-way request picker.
//   req      in   2  request vector, bit i = master i
//   last     in   1  index of the master granted most recently
//   mask     in   2  masters excluded from this pick
//   gnt_vld  out  1  some unmasked master is requesting
//   gnt_idx  out  1  index of the chosen master (0 when nothing is picked)
// ROUND_ROBIN = 1 breaks a tie in favour of the master not granted last;
// ROUND_ROBIN = 0 always breaks a tie in favour of master 0.
module sbc16_rr_pick2
    import sbc16_bus_pkg::*;
#(
    parameter bit ROUND_ROBIN = 1'b1
) (
    input  logic [1:0] req,
    input  logic       last,
    input  logic [1:0] mask,
    output logic       gnt_vld,
    output logic       gnt_idx
);

    logic [1:0] eligible;

    always_comb begin
        eligible = req & ~mask;
        gnt_vld  = |eligible;
        gnt_idx  = M_CPU;
        case (eligible)
            2'b10:   gnt_idx = M_LDR;
            2'b11:   gnt_idx = ROUND_ROBIN ? ~last : M_CPU;
            default: gnt_idx = M_CPU;
        endcase
    end

endmodule

// File: rtl/sbc16_mem_arbiter.sv
// sbc16_mem_arbiter
// Shares the single-port synchronous-read system RAM between the CPU
// (master 0) and a debug/loader master (master 1). Each access runs
// IDLE/RESP (pick + capture) -> ISSUE (drive RAM) -> RESP (ack + rdata).
//   clk, reset              25 MHz clock, synchronous active-high reset
//   mN_req/we/addr/wdata    master N request, held until mN_ack
//   mN_ack                  one-cycle completion pulse to master N
//   m_rdata                 read data, meaningful only in an ack cycle
//   mem_addr/we/wdata       RAM command, valid in the ISSUE cycle
//   mem_rdata               RAM read data, one cycle after the address
module sbc16_mem_arbiter
    import sbc16_bus_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int ROUND_ROBIN = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m0_ack,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_e            state_q, state_d;
    logic              owner_q, owner_d;
    logic              last_q,  last_d;
    logic              we_q,    we_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic [1:0] req_vec;
    logic [1:0] pick_mask;
    logic       gnt_vld;
    logic       gnt_idx;

    assign req_vec = {m1_req, m0_req};

    // In the owner's ack cycle its own request is masked so the other
    // master can be captured immediately; this is what prevents starvation
    // in fixed-priority mode.
    assign pick_mask = (state_q == RESP) ? ((owner_q == M_LDR) ? 2'b10 : 2'b01)
                                         : 2'b00;

    sbc16_rr_pick2 #(
        .ROUND_ROBIN (ROUND_ROBIN != 0)
    ) u_pick (
        .req     (req_vec),
        .last    (last_q),
        .mask    (pick_mask),
        .gnt_vld (gnt_vld),
        .gnt_idx (gnt_idx)
    );

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            IDLE, RESP: begin
                if (gnt_vld) begin
                    state_d = ISSUE;
                    owner_d = gnt_idx;
                    last_d  = gnt_idx;
                    if (gnt_idx == M_LDR) begin
                        we_d    = m1_we;
                        addr_d  = m1_addr;
                        wdata_d = m1_wdata;
                    end else begin
                        we_d    = m0_we;
                        addr_d  = m0_addr;
                        wdata_d = m0_wdata;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE:   state_d = RESP;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are gated by reset so an abandoned transaction neither
    // writes the RAM nor acknowledges in the reset cycle.
    always_comb begin
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        mem_we    = (state_q == ISSUE) && we_q && !reset;
        m0_ack    = (state_q == RESP) && (owner_q == M_CPU) && !reset;
        m1_ack    = (state_q == RESP) && (owner_q == M_LDR) && !reset;
        m_rdata   = ((state_q == RESP) && !reset) ? mem_rdata : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            owner_q <= M_CPU;
            last_q  <= M_LDR;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

endmodule
